sc_readback_checker: RTL and testbench
======================================

SC_READBACK_CHECKER -- requirements
Module: sc_readback_checker

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 829, meaning the number of serial bits per slow-control frame.
REQ-002 The block SHALL have parameter START_DELAY, default 1, meaning the clock cycles from start_in acceptance to the first sampled bit (range 0..15).
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock, the same 5 MHz clock that drives CK_SC; all sampling is on its rising edge.
REQ-004 The block SHALL have port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start_in, input, 1 bit: one-cycle pulse that arms a capture.
REQ-006 The block SHALL have port expected_frame_in, input, FRAME_LEN bits: the reference frame, where bit i is the i-th bit shifted (LSB first).
REQ-007 The block SHALL have port Q_SC_in, input, 1 bit: serial readback data from the MAROC slow-control chain.
REQ-008 The block SHALL have port busy_out, output, 1 bit: high in WAIT and CAPTURE.
REQ-009 The block SHALL have port done_out, output, 1 bit: one-cycle pulse at the end of a capture.
REQ-010 The block SHALL have port match_out, output, 1 bit: high when the last completed capture had zero errors.
REQ-011 The block SHALL have port err_cnt_out, output, 10 bits: the mismatch count of the last or current capture.
REQ-012 The block SHALL have port first_err_idx_out, output, 10 bits: the index of the first mismatching bit; 10'h3FF means none.
REQ-013 The block SHALL have port state_out, output, 2 bits: the current FSM state.
REQ-014 The block SHALL have port captured_frame_out, output, FRAME_LEN bits: the captured frame (see REQ-030).

Function
REQ-015 The FSM SHALL have states IDLE=0, WAIT=1, CAPTURE=2, DONE=3, with a registered state.
REQ-016 In IDLE or DONE, start_in=1 SHALL latch expected_frame_in, clear err_cnt_out to 0, set first_err_idx_out to 10'h3FF, clear match_out, and move to WAIT (or to CAPTURE if START_DELAY=0).
REQ-017 WAIT SHALL count START_DELAY cycles, then move to CAPTURE.
REQ-018 In CAPTURE, each cycle SHALL sample Q_SC_in as bit index idx (0..FRAME_LEN-1), incrementing idx after each sample.
REQ-019 The sampled bit SHALL be compared with latched expected bit idx; a mismatch SHALL increment err_cnt_out, saturating at 10'h3FF.
REQ-020 On the first mismatch of a capture, first_err_idx_out SHALL be loaded with idx; later mismatches SHALL NOT change it.
REQ-021 After sampling idx=FRAME_LEN-1, the FSM SHALL enter DONE and assert done_out for exactly that one cycle.
REQ-022 match_out SHALL be set on DONE entry when the final err_cnt_out (including the last bit) is 0, and SHALL hold until the next accepted start_in.
REQ-023 Capture latency SHALL be START_DELAY+FRAME_LEN cycles from the start_in edge to done_out (830 cycles with defaults).
REQ-024 start_in while busy_out=1 SHALL be ignored; the running capture and its latched expectation SHALL be unaffected.
REQ-025 start_in in the same cycle as done_out SHALL be accepted, beginning a new capture the next cycle.
REQ-026 Changes on expected_frame_in after acceptance SHALL NOT affect the current capture.
REQ-027 An illegal state value SHALL return the FSM to IDLE on the next clock.

Reset
REQ-028 On reset_in=1, asynchronously: state SHALL be IDLE; busy_out, done_out, match_out, err_cnt_out, idx, and the delay counter SHALL be 0; first_err_idx_out SHALL be 10'h3FF; captured_frame_out SHALL be 0.
REQ-029 Reset asserted mid-capture SHALL abort the capture with no done_out pulse, and the next start_in after release SHALL capture normally.

Configuration
REQ-030 With macro SC_READBACK_CAPTURE_EN defined, each sampled bit SHALL be stored at captured_frame_out[idx], and the stored frame SHALL hold after DONE until the next accepted start_in clears it.
REQ-031 Without SC_READBACK_CAPTURE_EN, captured_frame_out SHALL be constant 0, no frame storage SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-032 Verification SHALL cover: expected = alternating 1010..., Q_SC_in driving the same pattern -> done_out at cycle 830, match_out=1, err_cnt_out=0, first_err_idx_out=10'h3FF.
REQ-033 Verification SHALL cover: expected all 0, Q_SC_in=1 at indices 5 and 700 only -> err_cnt_out=2, first_err_idx_out=5, match_out=0.
REQ-034 Verification SHALL cover: expected all 0, Q_SC_in held at 1 -> err_cnt_out=829, first_err_idx_out=0.
REQ-035 Verification SHALL cover: second start_in at capture index 300 -> ignored, and a single done_out at cycle 830.
REQ-036 Verification SHALL cover: reset_in pulsed at index 400 -> all outputs at reset values immediately and no done_out; a following capture of a matching frame -> match_out=1.
REQ-037 Verification SHALL cover: with SC_READBACK_CAPTURE_EN, a random frame driven on Q_SC_in -> captured_frame_out equals that frame after done_out; without the macro, captured_frame_out stays 0.

Source files
------------

// File: rtl/sc_readback_checker.sv
// Slow-control readback checker: captures FRAME_LEN serial bits from Q_SC_in and compares them
// with a latched reference frame. Optional frame storage is enabled by macro SC_READBACK_CAPTURE_EN.
module sc_readback_checker #(
    parameter int FRAME_LEN   = 829,
    parameter int START_DELAY = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 start_in,
    input  logic [FRAME_LEN-1:0] expected_frame_in,
    input  logic                 Q_SC_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 match_out,
    output logic [9:0]           err_cnt_out,
    output logic [9:0]           first_err_idx_out,
    output logic [1:0]           state_out,
    output logic [FRAME_LEN-1:0] captured_frame_out
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [3:0] DLY_LAST = (START_DELAY > 0) ? 4'(START_DELAY - 1) : 4'd0;
    localparam logic [9:0] NO_ERR = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [3:0]           r_dly;
    logic [FRAME_LEN-1:0] r_exp;
    logic [9:0]           r_err_cnt;
    logic [9:0]           r_first_err;
    logic                 r_match;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_mismatch;

    assign w_accept   = start_in && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_idx == IDX_LAST);
    assign w_mismatch = (r_state == S_CAPTURE) && (Q_SC_in != r_exp[r_idx]);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    w_next = (START_DELAY == 0) ? S_CAPTURE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_dly == DLY_LAST) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_idx       <= '0;
            r_dly       <= 4'd0;
            r_exp       <= '0;
            r_err_cnt   <= 10'd0;
            r_first_err <= NO_ERR;
            r_match     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_CAPTURE) && w_last;
            if (w_accept) begin
                r_exp       <= expected_frame_in;
                r_err_cnt   <= 10'd0;
                r_first_err <= NO_ERR;
                r_match     <= 1'b0;
                r_idx       <= '0;
                r_dly       <= 4'd0;
            end else begin
                if (r_state == S_WAIT) begin
                    r_dly <= r_dly + 4'd1;
                end
                if (r_state == S_CAPTURE) begin
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    if (w_mismatch) begin
                        if (r_err_cnt != NO_ERR) begin
                            r_err_cnt <= r_err_cnt + 10'd1;
                        end
                        // a zero count means no earlier mismatch in this capture
                        if (r_err_cnt == 10'd0) begin
                            r_first_err <= 10'(r_idx);
                        end
                    end
                    if (w_last) begin
                        r_match <= (r_err_cnt == 10'd0) && !w_mismatch;
                    end
                end
            end
        end
    end

`ifdef SC_READBACK_CAPTURE_EN
    logic [FRAME_LEN-1:0] r_cap;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_cap <= '0;
        end else if (w_accept) begin
            r_cap <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_cap[r_idx] <= Q_SC_in;
        end
    end

    assign captured_frame_out = r_cap;
`else
    assign captured_frame_out = '0;
`endif

    assign busy_out          = (r_state == S_WAIT) || (r_state == S_CAPTURE);
    assign done_out          = r_done;
    assign match_out         = r_match;
    assign err_cnt_out       = r_err_cnt;
    assign first_err_idx_out = r_first_err;
    assign state_out         = r_state;

endmodule

// File: tb/tb_sc_readback_checker.sv
// Bench for sc_readback_checker: table vectors for the named frames, random frames checked
// against a mismatch-count model, plus hand sequences for ignored restart and mid-capture reset.
module tb_sc_readback_checker;
    localparam int FL  = 829;
    localparam int SD  = 1;
    localparam int LAT = SD + FL;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          start_in;
    logic [FL-1:0] expected_frame_in;
    logic          Q_SC_in;
    logic          busy_out;
    logic          done_out;
    logic          match_out;
    logic [9:0]    err_cnt_out;
    logic [9:0]    first_err_idx_out;
    logic [1:0]    state_out;
    logic [FL-1:0] captured_frame_out;

    sc_readback_checker #(
        .FRAME_LEN  (FL),
        .START_DELAY(SD)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .start_in          (start_in),
        .expected_frame_in (expected_frame_in),
        .Q_SC_in           (Q_SC_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .match_out         (match_out),
        .err_cnt_out       (err_cnt_out),
        .first_err_idx_out (first_err_idx_out),
        .state_out         (state_out),
        .captured_frame_out(captured_frame_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [FL-1:0] exp_f;
        logic [FL-1:0] q_f;
        int            errs;
        int            first;
        bit            match;
    } vec_t;

    vec_t tbl[3];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FL-1:0] act, input logic [FL-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    function automatic int model_errs(input logic [FL-1:0] e, input logic [FL-1:0] q);
        int n = 0;
        for (int i = 0; i < FL; i++) if (e[i] != q[i]) n++;
        return (n > 1023) ? 1023 : n;
    endfunction

    function automatic int model_first(input logic [FL-1:0] e, input logic [FL-1:0] q);
        for (int i = 0; i < FL; i++) if (e[i] != q[i]) return i;
        return 1023;
    endfunction

    function automatic logic [FL-1:0] rand_frame();
        logic [FL-1:0] f;
        for (int i = 0; i < FL; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    function automatic logic [FL-1:0] model_cap(input logic [FL-1:0] q);
`ifdef SC_READBACK_CAPTURE_EN
        return q;
`else
        return '0;
`endif
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state_out), 0);
        chk({tag, "_busy"}, 32'(busy_out), 0);
        chk({tag, "_done"}, 32'(done_out), 0);
        chk({tag, "_match"}, 32'(match_out), 0);
        chk({tag, "_err"}, 32'(err_cnt_out), 0);
        chk({tag, "_first"}, 32'(first_err_idx_out), 1023);
        chk_frame({tag, "_cap"}, captured_frame_out, '0);
    endtask

    // Called at a negedge; returns at the negedge where done_out is seen (or after the budget).
    task automatic run_capture(input logic [FL-1:0] exp_f, input logic [FL-1:0] q_f,
                               input int restart_at, output int lat);
        int k;
        expected_frame_in = exp_f;
        start_in          = 1'b1;
        Q_SC_in           = 1'b0;
        @(posedge clk_in);
        lat = -1;
        for (int cyc = 0; cyc < LAT + 50; cyc++) begin
            @(negedge clk_in);
            start_in          = 1'b0;
            expected_frame_in = ~exp_f;
            if (cyc == 0) chk("busy_after_start", 32'(busy_out), 1);
            if (done_out) begin
                lat = cyc;
                break;
            end
            k = cyc - SD;
            Q_SC_in = (k >= 0 && k < FL) ? q_f[k] : 1'b0;
            if (k == restart_at) start_in = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int errs, input int first,
                                input bit match, input logic [FL-1:0] q_f);
        chk({tag, "_latency"}, 32'(lat), LAT);
        chk({tag, "_err_cnt"}, 32'(err_cnt_out), 32'(errs));
        chk({tag, "_first_idx"}, 32'(first_err_idx_out), 32'(first));
        chk({tag, "_match"}, 32'(match_out), 32'(match));
        chk({tag, "_state_done"}, 32'(state_out), 3);
        chk({tag, "_busy_low"}, 32'(busy_out), 0);
        chk_frame({tag, "_captured"}, captured_frame_out, model_cap(q_f));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FL-1:0] alt;
        logic [FL-1:0] z;
        logic [FL-1:0] q5;
        logic [FL-1:0] e;
        logic [FL-1:0] q;
        int            lat;
        int            dones;
        int            k;

        reset_in          = 1'b1;
        start_in          = 1'b0;
        Q_SC_in           = 1'b0;
        expected_frame_in = '0;
        repeat (3) @(negedge clk_in);
        chk_reset("reset");
        reset_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < FL; i++) alt[i] = (i % 2 == 0);
        z  = '0;
        q5 = '0;
        q5[5]   = 1'b1;
        q5[700] = 1'b1;
        tbl[0].exp_f = alt; tbl[0].q_f = alt; tbl[0].errs = 0;   tbl[0].first = 1023; tbl[0].match = 1;
        tbl[1].exp_f = z;   tbl[1].q_f = q5;  tbl[1].errs = 2;   tbl[1].first = 5;    tbl[1].match = 0;
        tbl[2].exp_f = z;   tbl[2].q_f = ~z;  tbl[2].errs = 829; tbl[2].first = 0;    tbl[2].match = 0;

        // consecutive calls start at the done_out cycle, so each one also exercises start-on-done
        for (int t = 0; t < 3; t++) begin
            run_capture(tbl[t].exp_f, tbl[t].q_f, -1, lat);
            check_result($sformatf("vec%0d", t), lat, tbl[t].errs, tbl[t].first, tbl[t].match, tbl[t].q_f);
        end

        // start pulse at capture index 300 must be ignored
        e = rand_frame();
        run_capture(e, e, 300, lat);
        check_result("restart_ignored", lat, 0, 1023, 1, e);
        @(negedge clk_in);
        chk("single_done_pulse", 32'(done_out), 0);
        chk("match_holds", 32'(match_out), 1);
        @(negedge clk_in);

        for (int r = 0; r < 6; r++) begin
            e = rand_frame();
            q = e;
            if (r == 1) q = rand_frame();
            else if (r > 1) begin
                for (int i = 0; i < FL; i++) if ($urandom_range(0, 63) == 0) q[i] = ~q[i];
            end
            run_capture(e, q, -1, lat);
            check_result($sformatf("rand%0d", r), lat, model_errs(e, q), model_first(e, q),
                         model_errs(e, q) == 0, q);
        end

        // reset in the middle of a failing capture
        @(negedge clk_in);
        expected_frame_in = '0;
        start_in          = 1'b1;
        @(posedge clk_in);
        for (int cyc = 0; cyc < LAT; cyc++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            k = cyc - SD;
            if (k == 400) break;
            Q_SC_in = 1'b1;
        end
        chk("err_before_reset", 32'(err_cnt_out), 400);
        reset_in = 1'b1;
        #1;
        chk_reset("async_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        dones    = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk_in);
            if (done_out) dones++;
        end
        chk("no_done_after_abort", 32'(dones), 0);
        chk("idle_after_abort", 32'(state_out), 0);

        run_capture(alt, alt, -1, lat);
        check_result("after_reset", lat, 0, 1023, 1, alt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
